// File: rtl/multi_operand_logic_unit.sv
// Register-mapped compute block: N_OPS operand FIFOs are combined with a selectable
// operator (OR/AND/XOR/SUM) into a result FIFO, which is drained through an addressed read port.
module multi_operand_logic_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int N_OPS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       write_addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic             write_en,
  output logic             write_ready,
  input  logic [3:0]       read_addr,
  input  logic             read_en,
  output logic [WIDTH-1:0] read_data,
  output logic             read_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [1:0] MODE_OR  = 2'd0;
  localparam logic [1:0] MODE_AND = 2'd1;
  localparam logic [1:0] MODE_XOR = 2'd2;

  logic [WIDTH-1:0] op_head [N_OPS];
  logic [N_OPS-1:0] op_full;
  logic [N_OPS-1:0] op_avail;
  logic [1:0]       mode_reg;
  logic [1:0]       mode_in;
  logic             write_fire;
  logic             read_fire;
  logic             fire;
  logic             res_pop;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] read_value;
  logic [WIDTH-1:0] res_mem [DEPTH];
  logic [PW-1:0]    res_wr_ptr_reg;
  logic [PW-1:0]    res_rd_ptr_reg;
  logic [CW-1:0]    res_count_reg;
  logic             res_full;
  logic             res_avail;

  // All handshake and fire decisions use pre-edge counts only.
  assign res_full   = res_count_reg == CW'(DEPTH);
  assign res_avail  = res_count_reg != '0;
  assign fire       = (&op_avail) && !res_full;
  assign write_fire = write_en && write_ready;
  assign read_ready = (read_addr == 4'd9) ? res_avail : 1'b1;
  assign read_fire  = read_en && read_ready;
  assign res_pop    = read_fire && (read_addr == 4'd9);

  always_comb begin
    write_ready = 1'b1;
    for (int k = 0; k < N_OPS; k++) begin
      if (write_addr == 4'(k)) write_ready = !op_full[k];
    end
  end

  generate
    if (WIDTH >= 2) begin : g_mode_wide
      assign mode_in = write_data[1:0];
    end else begin : g_mode_narrow
      assign mode_in = {1'b0, write_data[0]};
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < N_OPS; gi++) begin : g_chan
      logic [WIDTH-1:0] mem [DEPTH];
      logic [PW-1:0]    wr_ptr_reg;
      logic [PW-1:0]    rd_ptr_reg;
      logic [CW-1:0]    count_reg;
      logic             push;

      assign push         = write_fire && (write_addr == 4'(gi));
      assign op_head[gi]  = mem[rd_ptr_reg];
      assign op_full[gi]  = count_reg == CW'(DEPTH);
      assign op_avail[gi] = count_reg != '0;

      always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= write_data;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (fire) rd_ptr_reg <= rd_ptr_reg + 1'b1;
          case ({push, fire})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

  // Fold operands in channel order; SUM wraps at WIDTH bits.
  always_comb begin
    result = op_head[0];
    for (int k = 1; k < N_OPS; k++) begin
      case (mode_reg)
        MODE_OR:  result = result | op_head[k];
        MODE_AND: result = result & op_head[k];
        MODE_XOR: result = result ^ op_head[k];
        default:  result = result + op_head[k];
      endcase
    end
  end

  always_comb begin
    read_value = '0;
    for (int k = 0; k < N_OPS; k++) begin
      if (read_addr == 4'(k)) read_value[0] = !op_full[k];
    end
    case (read_addr)
      4'd8:    read_value[0] = res_avail;
      4'd9:    read_value    = res_mem[res_rd_ptr_reg];
      4'd10:   read_value    = WIDTH'(res_count_reg);
      4'd11:   read_value    = WIDTH'(mode_reg);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fire) res_mem[res_wr_ptr_reg] <= result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_wr_ptr_reg <= '0;
      res_rd_ptr_reg <= '0;
      res_count_reg  <= '0;
      mode_reg       <= '0;
      read_data      <= '0;
    end else begin
      if (fire)    res_wr_ptr_reg <= res_wr_ptr_reg + 1'b1;
      if (res_pop) res_rd_ptr_reg <= res_rd_ptr_reg + 1'b1;
      case ({fire, res_pop})
        2'b10:   res_count_reg <= res_count_reg + 1'b1;
        2'b01:   res_count_reg <= res_count_reg - 1'b1;
        default: res_count_reg <= res_count_reg;
      endcase
      if (write_fire && (write_addr == 4'd8)) mode_reg <= mode_in;
      if (read_fire) read_data <= read_value;
    end
  end
endmodule

// File: tb/tb_multi_operand_logic_unit.sv
// Bench for multi_operand_logic_unit: queue-based reference model checked every cycle,
// plus literal expectations on a 2-channel and a 3-channel instance.
module tb_multi_operand_logic_unit;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, write_en, read_en, write_ready, read_ready;
  logic [3:0] write_addr, read_addr;
  logic [7:0] write_data, read_data;

  logic       t_reset, t_write_en, t_read_en, t_write_ready, t_read_ready;
  logic [3:0] t_write_addr, t_read_addr;
  logic [7:0] t_write_data, t_read_data;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit lit_valid = 1'b0;
  bit lit_sel = 1'b0;
  logic [7:0] lit_val;
  int lit_id;

  always #5 clk = ~clk;

  multi_operand_logic_unit #(.WIDTH(8), .DEPTH(DEPTH), .N_OPS(2)) dut (
    .clk(clk), .reset(reset),
    .write_addr(write_addr), .write_data(write_data), .write_en(write_en), .write_ready(write_ready),
    .read_addr(read_addr), .read_en(read_en), .read_data(read_data), .read_ready(read_ready)
  );

  multi_operand_logic_unit #(.WIDTH(8), .DEPTH(DEPTH), .N_OPS(3)) dut3 (
    .clk(clk), .reset(t_reset),
    .write_addr(t_write_addr), .write_data(t_write_data), .write_en(t_write_en), .write_ready(t_write_ready),
    .read_addr(t_read_addr), .read_en(t_read_en), .read_data(t_read_data), .read_ready(t_read_ready)
  );

  // Reference model for the 2-channel instance: plain queues.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] rq[$];
  logic [1:0] m_mode = 2'd0;
  logic [7:0] m_rd = 8'd0;
  bit         m_wr_ok, m_rd_ok, m_go;
  logic [7:0] m_res;

  function automatic bit exp_wready(logic [3:0] a);
    if (a == 4'd0) return q0.size() < DEPTH;
    if (a == 4'd1) return q1.size() < DEPTH;
    return 1'b1;
  endfunction

  function automatic bit exp_rready(logic [3:0] a);
    if (a == 4'd9) return rq.size() > 0;
    return 1'b1;
  endfunction

  function automatic logic [7:0] combine(logic [1:0] m, logic [7:0] a, logic [7:0] b);
    int s;
    s = (int'(a) + int'(b)) % 256;
    case (m)
      2'd0:    return a | b;
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return 8'(s);
    endcase
  endfunction

  function automatic logic [7:0] model_read(logic [3:0] a);
    case (a)
      4'd0:    return {7'd0, q0.size() < DEPTH};
      4'd1:    return {7'd0, q1.size() < DEPTH};
      4'd8:    return {7'd0, rq.size() > 0};
      4'd9:    return (rq.size() > 0) ? rq[0] : 8'd0;
      4'd10:   return 8'(rq.size());
      4'd11:   return {6'd0, m_mode};
      default: return 8'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q0.delete(); q1.delete(); rq.delete();
      m_mode = 2'd0;
      m_rd   = 8'd0;
    end else begin
      m_wr_ok = write_en && exp_wready(write_addr);
      m_rd_ok = read_en && exp_rready(read_addr);
      m_go    = (q0.size() > 0) && (q1.size() > 0) && (rq.size() < DEPTH);
      m_res   = 8'd0;
      if (m_go) m_res = combine(m_mode, q0[0], q1[0]);
      if (m_rd_ok) m_rd = model_read(read_addr);
      if (m_go) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      if (m_rd_ok && read_addr == 4'd9) void'(rq.pop_front());
      if (m_go) rq.push_back(m_res);
      if (m_wr_ok) begin
        if (write_addr == 4'd0) q0.push_back(write_data);
        else if (write_addr == 4'd1) q1.push_back(write_data);
        else if (write_addr == 4'd8) m_mode = write_data[1:0];
      end
    end
  end

  // Single compare process: outputs are sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checks += 3;
      if (write_ready !== exp_wready(write_addr)) begin
        errors++;
        $display("FAIL write_ready t=%0t addr=%0d got %b want %b", $time, write_addr, write_ready, exp_wready(write_addr));
      end
      if (read_ready !== exp_rready(read_addr)) begin
        errors++;
        $display("FAIL read_ready t=%0t addr=%0d got %b want %b", $time, read_addr, read_ready, exp_rready(read_addr));
      end
      if (read_data !== m_rd) begin
        errors++;
        $display("FAIL read_data t=%0t got %h want %h", $time, read_data, m_rd);
      end
      if (lit_valid) begin
        checks++;
        if ((lit_sel ? t_read_data : read_data) !== lit_val) begin
          errors++;
          $display("FAIL literal_%0d dut%0d got %h want %h", lit_id, lit_sel ? 3 : 2,
                   lit_sel ? t_read_data : read_data, lit_val);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    write_en = 1'b1; write_addr = a; write_data = d;
    cycle();
    write_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    read_en = 1'b1; read_addr = a;
    cycle();
    read_en = 1'b0;
  endtask

  task automatic read_lit(input logic [3:0] a, input logic [7:0] v, input int id);
    rd(a);
    lit_valid = 1'b1; lit_sel = 1'b0; lit_val = v; lit_id = id;
    cycle();
    lit_valid = 1'b0;
  endtask

  task automatic t_wr(input logic [3:0] a, input logic [7:0] d);
    t_write_en = 1'b1; t_write_addr = a; t_write_data = d;
    cycle();
    t_write_en = 1'b0;
  endtask

  task automatic t_lit(input logic [3:0] a, input logic [7:0] v, input int id);
    t_read_en = 1'b1; t_read_addr = a;
    cycle();
    t_read_en = 1'b0;
    lit_valid = 1'b1; lit_sel = 1'b1; lit_val = v; lit_id = id;
    cycle();
    lit_valid = 1'b0;
  endtask

  logic [3:0] waddrs [6];
  logic [3:0] raddrs [9];

  initial begin
    reset = 1'b1; write_en = 1'b0; read_en = 1'b0; write_addr = 4'd0; read_addr = 4'd9; write_data = 8'd0;
    t_reset = 1'b1; t_write_en = 1'b0; t_read_en = 1'b0; t_write_addr = 4'd0; t_read_addr = 4'd0; t_write_data = 8'd0;
    cycle(); cycle();
    chk_en = 1'b1;
    reset = 1'b0; t_reset = 1'b0;

    // Three-channel instance: SUM wraps, reset flushes pending results and mode.
    t_wr(4'd8, 8'd3);
    t_wr(4'd0, 8'h80); t_wr(4'd1, 8'h80); t_wr(4'd2, 8'h01);
    cycle(); cycle(); cycle();
    t_lit(4'd9, 8'h01, 100);
    t_wr(4'd0, 8'h01); t_wr(4'd1, 8'h02); t_wr(4'd2, 8'h03);
    t_wr(4'd0, 8'h04); t_wr(4'd1, 8'h05); t_wr(4'd2, 8'h06);
    cycle(); cycle(); cycle();
    t_lit(4'd10, 8'd2, 101);
    t_lit(4'd11, 8'd3, 102);
    t_reset = 1'b1; cycle(); t_reset = 1'b0;
    t_lit(4'd10, 8'd0, 103);
    t_lit(4'd11, 8'd0, 104);

    // Reset-state reads.
    read_lit(4'd0, 8'd1, 1);
    read_lit(4'd1, 8'd1, 2);
    read_lit(4'd8, 8'd0, 3);
    read_lit(4'd10, 8'd0, 4);
    read_lit(4'd11, 8'd0, 5);
    read_addr = 4'd9; cycle();

    // OR of complementary nibbles.
    wr(4'd0, 8'h0F); wr(4'd1, 8'hF0);
    cycle(); cycle();
    read_lit(4'd8, 8'd1, 6);
    read_lit(4'd9, 8'hFF, 7);
    read_lit(4'd10, 8'd0, 8);

    wr(4'd8, 8'd1); wr(4'd0, 8'hCC); wr(4'd1, 8'hAA); cycle(); cycle();
    read_lit(4'd9, 8'h88, 9);
    wr(4'd8, 8'd2); wr(4'd0, 8'hCC); wr(4'd1, 8'hAA); cycle(); cycle();
    read_lit(4'd9, 8'h66, 10);
    wr(4'd8, 8'd3); wr(4'd0, 8'hC8); wr(4'd1, 8'h64); cycle(); cycle();
    read_lit(4'd9, 8'h2C, 11);
    // Mode change lands on the same edge as the fire: old mode (SUM) applies.
    wr(4'd0, 8'hCC); wr(4'd1, 8'hAA); wr(4'd8, 8'd1); cycle(); cycle();
    read_lit(4'd9, 8'h76, 12);
    read_lit(4'd11, 8'd1, 13);

    // Eight undrained pairs: result FIFO stops at 4, operand FIFOs hold the rest.
    wr(4'd8, 8'd0);
    for (int i = 1; i <= 8; i++) begin
      wr(4'd0, 8'(i));
      wr(4'd1, 8'(i << 4));
    end
    cycle();
    read_lit(4'd10, 8'd4, 14);
    read_lit(4'd0, 8'd0, 15);
    read_lit(4'd9, 8'h11, 16);
    read_lit(4'd10, 8'd4, 17);
    for (int i = 2; i <= 8; i++) read_lit(4'd9, 8'((i << 4) | i), 20 + i);
    read_lit(4'd10, 8'd0, 18);

    // Five writes to channel 0: the fifth is refused until a fire drains one.
    for (int i = 0; i < 5; i++) wr(4'd0, 8'(8'h40 + i));
    read_lit(4'd0, 8'd0, 30);
    wr(4'd1, 8'h01);
    write_addr = 4'd0;
    cycle();
    read_lit(4'd0, 8'd1, 31);

    // Randomized traffic against the model.
    waddrs = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd8, 4'd5};
    raddrs = '{4'd0, 4'd1, 4'd8, 4'd9, 4'd9, 4'd9, 4'd10, 4'd11, 4'd3};
    reset = 1'b1; cycle(); reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 299) == 0);
      write_en   = ($urandom_range(0, 9) < 6);
      write_addr = waddrs[$urandom_range(0, 5)];
      write_data = 8'($urandom);
      read_en    = (n < 1500) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
      read_addr  = raddrs[$urandom_range(0, 8)];
      cycle();
    end
    reset = 1'b0; write_en = 1'b0; read_en = 1'b0;
    cycle(); cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_operand_logic_unit.md
# multi_operand_logic_unit

Parametrised, register-mapped compute block that succeeds the single-bit two-operand test DUT. It accepts WIDTH-bit operands into N_OPS per-channel FIFOs over an addressed write port and combines one entry from every channel with a run-time-selectable operator (OR/AND/XOR/SUM). Results go into a result FIFO, which is drained, along with status, through an addressed read port with ready handshakes. It sits directly under the cocotb wrapper as the next-generation DUT.

## Interface
- WIDTH, 8, operand/result data width (1..32)
- DEPTH, 4, entries per operand FIFO and in the result FIFO (power of two, 2..16)
- N_OPS, 2, number of operand channels (2..4)
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high reset
- write_addr  in  4  write target address
- write_data  in  WIDTH  write payload
- write_en  in  1  write request
- write_ready  out  1  write target can accept; write fires on write_en && write_ready
- read_addr  in  4  read target address
- read_en  in  1  read request
- read_data  out  WIDTH  registered read result, zero-extended
- read_ready  out  1  read target can respond; read fires on read_en && read_ready

## Operation
- Write map:
  - addr k (0..N_OPS-1): push write_data into operand FIFO k.
  - addr 8: mode <= write_data[1:0]. Modes: 0 OR, 1 AND, 2 XOR, 3 SUM.
  - Any other address is accepted and ignored.
- Read map:
  - addr k (0..N_OPS-1): bit0 = operand FIFO k not full.
  - addr 8: bit0 = result FIFO not empty.
  - addr 9: pop the result FIFO; returns its head.
  - addr 10: result FIFO occupancy (0..DEPTH).
  - addr 11: mode.
  - Any other address returns 0.
- write_ready (combinational from write_addr and registered counts):
  - addr k: !full[k].
  - Otherwise: 1.
- read_ready:
  - addr 9: result FIFO not empty.
  - Otherwise: 1.
- Fire condition: every operand FIFO is non-empty and the result FIFO is not full. Evaluated every cycle from registered counts.
- On fire:
  - Pop one entry from each operand FIFO.
  - Push f(op0..op[N_OPS-1]) into the result FIFO.
  - Operands combine in channel order 0..N_OPS-1.
- SUM is modulo 2^WIDTH; carries are discarded.
- Full-check uses the pre-edge count only:
  - A full operand FIFO refuses a write even if a fire pops it the same cycle.
  - A full result FIFO blocks a fire even if a read pops it the same cycle.
- A same-cycle push and pop on a non-full, non-empty FIFO leaves the count unchanged, and both take effect.
- A mode write takes effect for fires from the next cycle onward. A fire in the same cycle uses the old mode.
- FIFO pointers wrap modulo DEPTH. Occupancy is held as a separate count 0..DEPTH.

## Timing
- Reset (synchronous, effective at the first edge with reset=1):
  - All FIFOs empty, mode=0, read_data=0.
  - write_ready=1 for every address.
  - read_ready=0 at addr 9, 1 elsewhere.
- Reset asserted mid-operation flushes all FIFO contents and clears mode at that edge. No fire, write or read completes in that cycle.
- Write latency: a write accepted at edge t is visible in counts and status from cycle t+1.
- Compute latency: the fire condition is seen in cycle t+1, and the result is in the result FIFO from cycle t+2.
- Minimum operand-write to result-status-visible: 2 cycles.
- Read latency:
  - read_data updates at the edge where the read fires, so it is valid in the following cycle.
  - read_data holds its value when no read fires.
- Throughput: one fire per cycle while the condition holds. The result FIFO fills at one entry per cycle when undrained.
- A read of addr 9 while empty does not fire. read_data is unchanged and the FIFO is unchanged.

## Test plan
- Reset, then read addrs 0, 1, 8, 10, 11.
  - Required response: read_data = 1, 1, 0, 0, 0.
  - read_ready=0 at addr 9.
- Mode 0, WIDTH=8. Write 0x0F to addr 0 and 0xF0 to addr 1.
  - Addr 8 reads 1 no earlier than 2 cycles after the second write.
  - A read of addr 9 returns 0xFF, after which addr 10 reads 0.
- Modes 1/2/3 on pairs (0xCC,0xAA) and (0xC8,0x64).
  - AND 0x88, XOR 0x66, SUM 0x2C (wrap).
  - A mode write in the same cycle as a fire does not affect that fire's result.
- Write 5 entries to addr 0 only (DEPTH=4).
  - write_ready drops after the 4th write, and the 5th is held off.
  - Then write one entry to addr 1: a fire occurs and write_ready at addr 0 returns to 1 one cycle later.
- Fill both operand FIFOs with 8 pairs without reading results.
  - The result FIFO stops at occupancy 4, and the operand FIFOs retain their remaining pairs.
  - Popping one result lets exactly one further fire occur one cycle later.
  - All results come out in order.
- N_OPS=3, SUM mode, operands 0x80, 0x80, 0x01.
  - Result is 0x01.
  - Assert reset with 2 results pending: addr 10 reads 0 and addr 11 reads 0 afterwards.
